// File: rtl/temp_pkg.sv
// Shared definitions for the multi-channel temperature monitor.
// Holds the state encoding and the default threshold values.
// Optional build macro used elsewhere: LATCH_ALERTA_EN.
package temp_pkg;

   typedef enum logic [1:0] {
      EstNormal = 2'b00,
      EstFrio   = 2'b01,
      EstAlto   = 2'b10,
      EstAlerta = 2'b11
   } estado_temp_t;

   localparam int TEMP_FRIO_DEF = 180;
   localparam int TEMP_ALTO_DEF = 250;
   localparam int HIST_DEF      = 5;
   localparam int N_DEF         = 5;

endpackage

// File: rtl/monitor_temp_canales_if.sv
// Bundle between the scaling stage / actuator drivers and the monitor.
//   master: drives muestra_valida, temp_in, ack_alerta; observes all results
//   slave : the monitor itself
// Per-channel fields are packed, channel k at [k*width +: width].
interface monitor_temp_canales_if #(
   parameter int unsigned CANALES = 4,
   parameter int unsigned ANCHO   = 11,
   parameter int unsigned CNT_W   = 3
);
   logic [CANALES-1:0]       muestra_valida;
   logic [CANALES*ANCHO-1:0] temp_in;
   logic [CANALES-1:0]       ack_alerta;
   logic [2*CANALES-1:0]     estado_actual;
   logic [CANALES-1:0]       alerta;
   logic [CANALES-1:0]       calefactor;
   logic [CANALES-1:0]       ventilador;
   logic                     alerta_global;
   logic [CNT_W*CANALES-1:0] contador;

   modport master (
      output muestra_valida, temp_in, ack_alerta,
      input  estado_actual, alerta, calefactor, ventilador, alerta_global, contador
   );

   modport slave (
      input  muestra_valida, temp_in, ack_alerta,
      output estado_actual, alerta, calefactor, ventilador, alerta_global, contador
   );
endinterface

// File: rtl/canal_temp_fsm.sv
// One sensor channel: NORMAL/FRIO/ALTO/ALERTA FSM with saturating persistence
// counter, hysteresis band and heater/fan outputs. All outputs registered.
// Ports: clk, arst (async, active-high), valida (sample strobe), temp (signed
// sample), ack (only with LATCH_ALERTA_EN), estado, alerta, calefactor,
// ventilador, contador.
// Macro LATCH_ALERTA_EN: ALERTA is left only after an ack seen while the last
// valid sample was in band.
module canal_temp_fsm
   import temp_pkg::*;
#(
   parameter int unsigned ANCHO     = 11,
   parameter int          TEMP_FRIO = TEMP_FRIO_DEF,
   parameter int          TEMP_ALTO = TEMP_ALTO_DEF,
   parameter int          HIST      = HIST_DEF,
   parameter int unsigned N         = N_DEF,
   parameter int unsigned CNT_W     = 3
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic                    valida,
   input  logic signed [ANCHO-1:0] temp,
`ifdef LATCH_ALERTA_EN
   input  logic                    ack,
`endif
   output logic [1:0]              estado,
   output logic                    alerta,
   output logic                    calefactor,
   output logic                    ventilador,
   output logic [CNT_W-1:0]        contador
);

   localparam logic [1:0] ST_NORMAL = EstNormal;
   localparam logic [1:0] ST_FRIO   = EstFrio;
   localparam logic [1:0] ST_ALTO   = EstAlto;
   localparam logic [1:0] ST_ALERTA = EstAlerta;

   localparam logic signed [ANCHO-1:0] UMBRAL_FRIO = ANCHO'(TEMP_FRIO);
   localparam logic signed [ANCHO-1:0] UMBRAL_ALTO = ANCHO'(TEMP_ALTO);
   localparam logic signed [ANCHO-1:0] BANDA_BAJA  = ANCHO'(TEMP_FRIO + HIST);
   localparam logic signed [ANCHO-1:0] BANDA_ALTA  = ANCHO'(TEMP_ALTO - HIST);
   localparam logic [CNT_W-1:0]        CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]        CNT_UNO     = CNT_W'(1);
   localparam logic [CNT_W-1:0]        N_CNT       = CNT_W'(N);
   // A fresh excursion (count 1) already qualifies when N is 1.
   localparam logic                    ALERTA_INMEDIATA = (N <= 1);

   logic [1:0]       st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             al_q, al_d, cal_q, cal_d, ven_q, ven_d;
   logic             frio, caliente, en_banda;

   assign frio     = temp < UMBRAL_FRIO;
   assign caliente = temp > UMBRAL_ALTO;
   assign en_banda = (temp >= BANDA_BAJA) && (temp <= BANDA_ALTA);
   assign cnt_inc  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_UNO;

`ifdef LATCH_ALERTA_EN
   logic banda_q, banda_d;  // last valid sample was in band
`endif

   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      al_d  = al_q;
      cal_d = cal_q;
      ven_d = ven_q;
`ifdef LATCH_ALERTA_EN
      banda_d = valida ? en_banda : banda_q;
`endif
      if (valida) begin
         case (st_q)
            ST_NORMAL, ST_FRIO, ST_ALTO: begin
               if ((st_q != ST_NORMAL) && en_banda) begin
                  st_d  = ST_NORMAL;
                  cnt_d = '0;
               end else if (frio && (st_q == ST_FRIO)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= N_CNT) begin
                     st_d  = ST_ALERTA;
                     al_d  = 1'b1;
                     cal_d = 1'b1;
                  end
               end else if (caliente && (st_q == ST_ALTO)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= N_CNT) begin
                     st_d  = ST_ALERTA;
                     al_d  = 1'b1;
                     ven_d = 1'b1;
                  end
               end else if (frio || caliente) begin
                  // New excursion or side change: persistence restarts at 1.
                  cnt_d = CNT_UNO;
                  if (ALERTA_INMEDIATA) begin
                     st_d  = ST_ALERTA;
                     al_d  = 1'b1;
                     cal_d = frio;
                     ven_d = caliente;
                  end else begin
                     st_d = frio ? ST_FRIO : ST_ALTO;
                  end
               end else if (st_q == ST_NORMAL) begin
                  cnt_d = '0;
               end
            end
            ST_ALERTA: begin
               al_d = 1'b1;
               if (frio) begin
                  cal_d = 1'b1;
                  ven_d = 1'b0;
                  cnt_d = cnt_inc;
               end else if (caliente) begin
                  cal_d = 1'b0;
                  ven_d = 1'b1;
                  cnt_d = cnt_inc;
               end else if (en_banda) begin
                  cal_d = 1'b0;
                  ven_d = 1'b0;
`ifndef LATCH_ALERTA_EN
                  st_d  = ST_NORMAL;
                  cnt_d = '0;
                  al_d  = 1'b0;
`endif
               end
            end
            default: begin
               st_d  = ST_NORMAL;
               cnt_d = '0;
               al_d  = 1'b0;
               cal_d = 1'b0;
               ven_d = 1'b0;
            end
         endcase
      end
`ifdef LATCH_ALERTA_EN
      if ((st_q == ST_ALERTA) && ack && banda_d) begin
         st_d  = ST_NORMAL;
         cnt_d = '0;
         al_d  = 1'b0;
         cal_d = 1'b0;
         ven_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         st_q  <= ST_NORMAL;
         cnt_q <= '0;
         al_q  <= 1'b0;
         cal_q <= 1'b0;
         ven_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         al_q  <= al_d;
         cal_q <= cal_d;
         ven_q <= ven_d;
      end
   end

`ifdef LATCH_ALERTA_EN
   always_ff @(posedge clk or posedge arst) begin
      if (arst) banda_q <= 1'b0;
      else      banda_q <= banda_d;
   end
`endif

   assign estado     = st_q;
   assign contador   = cnt_q;
   assign alerta     = al_q;
   assign calefactor = cal_q;
   assign ventilador = ven_q;

endmodule

// File: rtl/monitor_temp_canales.sv
// Multi-channel temperature monitor: CANALES independent canal_temp_fsm
// instances plus a registered OR of all alerts.
// Ports: clk, arst (async, active-high), bus (monitor_temp_canales_if.slave:
// muestra_valida, temp_in, ack_alerta in; estado_actual, alerta, calefactor,
// ventilador, alerta_global, contador out).
// Macro LATCH_ALERTA_EN: alerts latch until acknowledged via ack_alerta.
module monitor_temp_canales
   import temp_pkg::*;
#(
   parameter int unsigned CANALES   = 4,
   parameter int unsigned ANCHO     = 11,
   parameter int          TEMP_FRIO = TEMP_FRIO_DEF,
   parameter int          TEMP_ALTO = TEMP_ALTO_DEF,
   parameter int          HIST      = HIST_DEF,
   parameter int unsigned N         = N_DEF,
   parameter int unsigned CNT_W     = 3
) (
   input logic                   clk,
   input logic                   arst,
   monitor_temp_canales_if.slave bus
);

   logic [2*CANALES-1:0]     estado_w;
   logic [CANALES-1:0]       alerta_w, cal_w, ven_w;
   logic [CNT_W*CANALES-1:0] cnt_w;
   logic                     global_q;

   for (genvar k = 0; k < CANALES; k++) begin : g_canal
      canal_temp_fsm #(
         .ANCHO     (ANCHO),
         .TEMP_FRIO (TEMP_FRIO),
         .TEMP_ALTO (TEMP_ALTO),
         .HIST      (HIST),
         .N         (N),
         .CNT_W     (CNT_W)
      ) u_canal (
         .clk        (clk),
         .arst       (arst),
         .valida     (bus.muestra_valida[k]),
         .temp       (bus.temp_in[k*ANCHO +: ANCHO]),
`ifdef LATCH_ALERTA_EN
         .ack        (bus.ack_alerta[k]),
`endif
         .estado     (estado_w[2*k +: 2]),
         .alerta     (alerta_w[k]),
         .calefactor (cal_w[k]),
         .ventilador (ven_w[k]),
         .contador   (cnt_w[k*CNT_W +: CNT_W])
      );
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) global_q <= 1'b0;
      else      global_q <= |alerta_w;
   end

   assign bus.estado_actual = estado_w;
   assign bus.alerta        = alerta_w;
   assign bus.calefactor    = cal_w;
   assign bus.ventilador    = ven_w;
   assign bus.contador      = cnt_w;
   assign bus.alerta_global = global_q;

endmodule

// File: tb/tb_monitor_temp_canales.sv
// Bench for monitor_temp_canales (4 channels, default thresholds, N=5).
// A behavioural model pushes expected outputs to a queue per stimulus cycle;
// each test pops and compares after the clock edge.
module tb_monitor_temp_canales;

   typedef struct packed {
      logic [7:0]  est;
      logic [3:0]  al;
      logic [3:0]  cal;
      logic [3:0]  ven;
      logic        glob;
      logic [11:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic arst;
   int   checks = 0;
   int   errors = 0;
   obs_t sb[$];
   obs_t exp_o, got_o;

   logic [1:0] m_st[4];
   int         m_cnt[4];
   logic       m_al[4], m_cal[4], m_ven[4], m_ok[4];
   logic       m_glob;

   monitor_temp_canales_if #(.CANALES(4), .ANCHO(11), .CNT_W(3)) bus ();

   monitor_temp_canales #(.CANALES(4), .ANCHO(11), .CNT_W(3)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got running want finished");
      $fatal(1);
   end

   function automatic obs_t observe();
      obs_t o;
      o.est  = bus.estado_actual;
      o.al   = bus.alerta;
      o.cal  = bus.calefactor;
      o.ven  = bus.ventilador;
      o.glob = bus.alerta_global;
      o.cnt  = bus.contador;
      return o;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 4; k++) begin
         m_st[k] = 2'b00; m_cnt[k] = 0; m_al[k] = 0; m_cal[k] = 0; m_ven[k] = 0; m_ok[k] = 0;
      end
      m_glob = 0;
   endfunction

   function automatic obs_t model_out();
      obs_t o;
      for (int k = 0; k < 4; k++) begin
         o.est[2*k +: 2] = m_st[k];
         o.al[k]         = m_al[k];
         o.cal[k]        = m_cal[k];
         o.ven[k]        = m_ven[k];
         o.cnt[3*k +: 3] = 3'(m_cnt[k]);
      end
      o.glob = m_glob;
      return o;
   endfunction

   function automatic void model_step(logic [3:0] v, int t[4], logic [3:0] ack);
      logic cold, hot, band;
      m_glob = m_al[0] | m_al[1] | m_al[2] | m_al[3];
      for (int k = 0; k < 4; k++) begin
         cold = t[k] < 180;
         hot  = t[k] > 250;
         band = (t[k] >= 185) && (t[k] <= 245);
         if (v[k]) begin
            if (m_st[k] == 2'b00) begin
               if (cold)     begin m_st[k] = 2'b01; m_cnt[k] = 1; end
               else if (hot) begin m_st[k] = 2'b10; m_cnt[k] = 1; end
               else m_cnt[k] = 0;
            end else if (m_st[k] == 2'b01 || m_st[k] == 2'b10) begin
               if (band) begin
                  m_st[k] = 2'b00; m_cnt[k] = 0;
               end else if ((cold && m_st[k] == 2'b01) || (hot && m_st[k] == 2'b10)) begin
                  m_cnt[k] = (m_cnt[k] < 7) ? m_cnt[k] + 1 : 7;
                  if (m_cnt[k] >= 5) begin
                     m_al[k] = 1; m_cal[k] = cold; m_ven[k] = hot; m_st[k] = 2'b11;
                  end
               end else if (cold || hot) begin
                  m_st[k] = cold ? 2'b01 : 2'b10; m_cnt[k] = 1;
               end
            end else begin
               if (cold || hot) begin
                  m_cal[k] = cold; m_ven[k] = hot;
                  m_cnt[k] = (m_cnt[k] < 7) ? m_cnt[k] + 1 : 7;
               end else if (band) begin
                  m_cal[k] = 0; m_ven[k] = 0;
`ifndef LATCH_ALERTA_EN
                  m_al[k] = 0; m_st[k] = 2'b00; m_cnt[k] = 0;
`endif
               end
            end
            m_ok[k] = band;
         end
`ifdef LATCH_ALERTA_EN
         if (m_st[k] == 2'b11 && ack[k] && m_ok[k] && !(v[k] && !band)) begin
            m_st[k] = 2'b00; m_cnt[k] = 0; m_al[k] = 0; m_cal[k] = 0; m_ven[k] = 0;
         end
`endif
      end
   endfunction

   // Drive one cycle of stimulus and queue the expected post-edge outputs.
   task automatic step(input logic [3:0] v, input int t0, input int t1, input int t2,
                       input int t3, input logic [3:0] ack);
      int t[4];
      t = '{t0, t1, t2, t3};
      model_step(v, t, ack);
      sb.push_back(model_out());
      bus.muestra_valida = v;
      bus.temp_in        = {11'(t3), 11'(t2), 11'(t1), 11'(t0)};
      bus.ack_alerta     = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      bus.muestra_valida = '0; bus.temp_in = '0; bus.ack_alerta = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      got_o = observe();
      checks++;
      if (got_o !== obs_t'(0)) begin
         errors++; $display("FAIL reset_state got=%h want=%h", got_o, obs_t'(0));
      end
      arst = 1'b0;
      step(4'b0000, 200, 200, 200, 200, 4'b0000);
      exp_o = sb.pop_front(); got_o = observe(); checks++;
      if (got_o !== exp_o) begin
         errors++; $display("FAIL reset_idle got=%h want=%h", got_o, exp_o);
      end
   endtask

   task automatic test_cold_persist();
      for (int i = 0; i < 5; i++) begin
         step(4'b0001, 150, 200, 200, 200, 4'b0000);
         exp_o = sb.pop_front(); got_o = observe(); checks++;
         if (got_o !== exp_o) begin
            errors++; $display("FAIL cold_step%0d got=%h want=%h", i, got_o, exp_o);
         end
         if (i == 0) begin
            checks++;
            if (got_o.est[1:0] !== 2'b01) begin
               errors++; $display("FAIL cold_first_state got=%b want=01", got_o.est[1:0]);
            end
         end
      end
      checks++;
      if (got_o.est[1:0] !== 2'b11 || got_o.cal[0] !== 1'b1 || got_o.ven[0] !== 1'b0 ||
          got_o.glob !== 1'b0) begin
         errors++;
         $display("FAIL cold_alert got est=%b cal=%b ven=%b glob=%b want 11 1 0 0",
                  got_o.est[1:0], got_o.cal[0], got_o.ven[0], got_o.glob);
      end
      step(4'b0000, 150, 200, 200, 200, 4'b0000);
      exp_o = sb.pop_front(); got_o = observe(); checks++;
      if (got_o !== exp_o || got_o.glob !== 1'b1) begin
         errors++; $display("FAIL global_lag got=%h want=%h", got_o, exp_o);
      end
   endtask

   task automatic test_hysteresis();
      int seq[6] = '{150, 182, 185, 300, 246, 245};
      logic [1:0] want_st[6] = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
      int want_cnt[6] = '{1, 1, 0, 1, 1, 0};
      for (int i = 0; i < 6; i++) begin
         step(4'b0010, 150, seq[i], 200, 200, 4'b0000);
         exp_o = sb.pop_front(); got_o = observe(); checks++;
         if (got_o !== exp_o || got_o.est[3:2] !== want_st[i] ||
             got_o.cnt[5:3] !== 3'(want_cnt[i])) begin
            errors++;
            $display("FAIL hyst_t%0d got=%h want=%h (state %b cnt %0d)", seq[i], got_o, exp_o,
                     want_st[i], want_cnt[i]);
         end
      end
   endtask

   task automatic test_side_change();
      int seq[9] = '{150, 150, 150, 300, 300, 300, 300, 300, 248};
      for (int i = 0; i < 9; i++) begin
         step(4'b0100, 150, 200, seq[i], 200, 4'b0000);
         exp_o = sb.pop_front(); got_o = observe(); checks++;
         if (got_o !== exp_o) begin
            errors++; $display("FAIL side_step%0d got=%h want=%h", i, got_o, exp_o);
         end
         if (i == 3 || i == 6) begin
            checks++;
            if (got_o.est[5:4] !== 2'b10) begin
               errors++; $display("FAIL side_alto%0d got=%b want=10", i, got_o.est[5:4]);
            end
         end
      end
      checks++;
      if (got_o.est[5:4] !== 2'b11 || got_o.ven[2] !== 1'b1 || got_o.cal[2] !== 1'b0) begin
         errors++; $display("FAIL side_alert_hold got est=%b ven=%b want 11 1",
                            got_o.est[5:4], got_o.ven[2]);
      end
   endtask

   task automatic test_exit();
      step(4'b0001, 215, 200, 248, 200, 4'b0000);
      exp_o = sb.pop_front(); got_o = observe(); checks++;
      if (got_o !== exp_o) begin
         errors++; $display("FAIL exit_band got=%h want=%h", got_o, exp_o);
      end
      checks++;
`ifdef LATCH_ALERTA_EN
      if (got_o.est[1:0] !== 2'b11 || got_o.al[0] !== 1'b1 || got_o.cal[0] !== 1'b0) begin
         errors++; $display("FAIL exit_latched got est=%b al=%b cal=%b want 11 1 0",
                            got_o.est[1:0], got_o.al[0], got_o.cal[0]);
      end
`else
      if (got_o.est[1:0] !== 2'b00 || got_o.al[0] !== 1'b0 || got_o.cal[0] !== 1'b0) begin
         errors++; $display("FAIL exit_direct got est=%b al=%b cal=%b want 00 0 0",
                            got_o.est[1:0], got_o.al[0], got_o.cal[0]);
      end
`endif
      step(4'b0000, 215, 200, 248, 200, 4'b0001);
      exp_o = sb.pop_front(); got_o = observe(); checks++;
      if (got_o !== exp_o || got_o.est[1:0] !== 2'b00 || got_o.al[0] !== 1'b0) begin
         errors++; $display("FAIL exit_ack got=%h want=%h", got_o, exp_o);
      end
   endtask

   task automatic test_gating();
      for (int i = 0; i < 5; i++) begin
         step(4'b0001, 150, 200, 248, -100, 4'b0000);
         exp_o = sb.pop_front(); got_o = observe(); checks++;
         if (got_o !== exp_o || got_o.est[7:6] !== 2'b00) begin
            errors++; $display("FAIL gate_step%0d got=%h want=%h", i, got_o, exp_o);
         end
      end
      checks++;
      if (got_o.est[1:0] !== 2'b11) begin
         errors++; $display("FAIL gate_ch0_alert got=%b want=11", got_o.est[1:0]);
      end
      step(4'b1000, 150, 200, 248, -100, 4'b0000);
      exp_o = sb.pop_front(); got_o = observe(); checks++;
      if (got_o !== exp_o || got_o.est[7:6] !== 2'b01) begin
         errors++; $display("FAIL gate_signed_cold got=%h want=%h", got_o, exp_o);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 4; i++) begin
         step(4'b0001, 150, 200, 248, -100, 4'b0000);
         exp_o = sb.pop_front(); got_o = observe(); checks++;
         if (got_o !== exp_o) begin
            errors++; $display("FAIL sat_step%0d got=%h want=%h", i, got_o, exp_o);
         end
      end
      checks++;
      if (got_o.cnt[2:0] !== 3'd7) begin
         errors++; $display("FAIL sat_count got=%0d want=7", got_o.cnt[2:0]);
      end
   endtask

   task automatic test_reset_mid();
      #2 arst = 1'b1;
      #1;
      model_reset();
      got_o = observe(); checks++;
      if (got_o !== obs_t'(0)) begin
         errors++; $display("FAIL reset_async got=%h want=%h", got_o, obs_t'(0));
      end
      #2 arst = 1'b0;
      @(posedge clk);
      #1;
      step(4'b1111, 200, 200, 200, 200, 4'b0000);
      exp_o = sb.pop_front(); got_o = observe(); checks++;
      if (got_o !== exp_o) begin
         errors++; $display("FAIL reset_after got=%h want=%h", got_o, exp_o);
      end
   endtask

   initial begin
      test_reset();
      test_cold_persist();
      test_hysteresis();
      test_side_change();
      test_exit();
      test_gating();
      test_saturation();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_left got=%0d want=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
